// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, the two cache refill engines and main memory.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 128
);
  logic              ic_req_valid;
  logic [AWIDTH-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic [DWIDTH-1:0] ic_resp_data;

  logic              dc_req_valid;
  logic              dc_req_rnw;
  logic [AWIDTH-1:0] dc_req_addr;
  logic [DWIDTH-1:0] dc_req_wdata;
  logic              dc_req_ready;
  logic              dc_resp_valid;
  logic [DWIDTH-1:0] dc_resp_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rnw;
  logic [AWIDTH-1:0] mem_req_addr;
  logic [DWIDTH-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DWIDTH-1:0] mem_resp_data;

  modport master (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_rnw, dc_req_addr, dc_req_wdata,
    output dc_req_ready, dc_resp_valid, dc_resp_data,
    output mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_rnw, dc_req_addr, dc_req_wdata,
    input  dc_req_ready, dc_resp_valid, dc_resp_data,
    input  mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one transaction at a time, data cache has priority.
// Define MEM_ARB_FAIRNESS_EN to bound instruction-cache starvation to STARVE_MAX data grants.
module mem_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_arbiter_if.master       bus,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rnw_q, rnw_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              ic_resp_valid_q, ic_resp_valid_d;
  logic              dc_resp_valid_q, dc_resp_valid_d;
  logic [DWIDTH-1:0] ic_resp_data_q, ic_resp_data_d;
  logic [DWIDTH-1:0] dc_resp_data_q, dc_resp_data_d;

  logic              force_ic_s;
  logic              grant_dc_s;
  logic              grant_ic_s;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0]        starve_q, starve_d;

  assign force_ic_s = bus.ic_req_valid && (starve_q == 4'(STARVE_MAX));
`else
  assign force_ic_s = 1'b0;
`endif

  assign grant_dc_s = (state_q == IDLE) && bus.dc_req_valid && !force_ic_s;
  assign grant_ic_s = (state_q == IDLE) && bus.ic_req_valid && !grant_dc_s;

  assign bus.ic_req_ready  = grant_ic_s;
  assign bus.dc_req_ready  = grant_dc_s;
  assign bus.ic_resp_valid = ic_resp_valid_q;
  assign bus.dc_resp_valid = dc_resp_valid_q;
  assign bus.ic_resp_data  = ic_resp_data_q;
  assign bus.dc_resp_data  = dc_resp_data_q;
  assign bus.mem_req_valid = (state_q == ISSUE);
  assign bus.mem_req_rnw   = rnw_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign busy              = (state_q != IDLE);
  assign owner             = owner_q;

  // Next-state, capture and response logic
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rnw_d           = rnw_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    ic_resp_valid_d = 1'b0;
    dc_resp_valid_d = 1'b0;
    ic_resp_data_d  = ic_resp_data_q;
    dc_resp_data_d  = dc_resp_data_q;
`ifdef MEM_ARB_FAIRNESS_EN
    starve_d        = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_dc_s) begin
          owner_d = 1'b1;
          rnw_d   = bus.dc_req_rnw;
          addr_d  = bus.dc_req_addr;
          wdata_d = bus.dc_req_wdata;
          state_d = ISSUE;
`ifdef MEM_ARB_FAIRNESS_EN
          // Only grants that make the instruction cache wait count toward starvation
          if (bus.ic_req_valid) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
`endif
        end else if (grant_ic_s) begin
          owner_d = 1'b0;
          rnw_d   = 1'b1;
          addr_d  = bus.ic_req_addr;
          wdata_d = {DWIDTH{1'b0}};
          state_d = ISSUE;
`ifdef MEM_ARB_FAIRNESS_EN
          starve_d = 4'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          state_d = rnw_q ? WAIT : IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          if (owner_q) begin
            dc_resp_valid_d = 1'b1;
            dc_resp_data_d  = bus.mem_resp_data;
          end else begin
            ic_resp_valid_d = 1'b1;
            ic_resp_data_d  = bus.mem_resp_data;
          end
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      rnw_q           <= 1'b0;
      addr_q          <= {AWIDTH{1'b0}};
      wdata_q         <= {DWIDTH{1'b0}};
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      ic_resp_data_q  <= {DWIDTH{1'b0}};
      dc_resp_data_q  <= {DWIDTH{1'b0}};
`ifdef MEM_ARB_FAIRNESS_EN
      starve_q        <= 4'd0;
`endif
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rnw_q           <= rnw_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      dc_resp_valid_q <= dc_resp_valid_d;
      ic_resp_data_q  <= ic_resp_data_d;
      dc_resp_data_q  <= dc_resp_data_d;
`ifdef MEM_ARB_FAIRNESS_EN
      starve_q        <= starve_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int SMAX = 2;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic owner;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  // {ic_ready, dc_ready, ic_resp_valid, dc_resp_valid, mem_req_valid, busy, owner}
  logic [6:0] st;
  assign st = {bus.ic_req_ready, bus.dc_req_ready, bus.ic_resp_valid, bus.dc_resp_valid,
               bus.mem_req_valid, busy, owner};

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_idle();
    bus.ic_req_valid   = 1'b0;
    bus.ic_req_addr    = 32'h0;
    bus.dc_req_valid   = 1'b0;
    bus.dc_req_rnw     = 1'b0;
    bus.dc_req_addr    = 32'h0;
    bus.dc_req_wdata   = 128'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 128'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (st !== 7'b0) begin n_fail++; $display("FAIL reset_status: got %b want %b", st, 7'b0); end
    n_checks++; if ({bus.mem_req_rnw, bus.mem_req_addr, bus.mem_req_wdata} !== 161'b0) begin n_fail++; $display("FAIL reset_memreq: got %h want 0", {bus.mem_req_rnw, bus.mem_req_addr, bus.mem_req_wdata}); end
    n_checks++; if ({bus.ic_resp_data, bus.dc_resp_data} !== 256'b0) begin n_fail++; $display("FAIL reset_respdata: got %h want 0", {bus.ic_resp_data, bus.dc_resp_data}); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (st !== 7'b0) begin n_fail++; $display("FAIL reset_release: got %b want %b", st, 7'b0); end
    n_checks++; if (bus.mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_release_addr: got %h want 0", bus.mem_req_addr); end
  endtask

  task automatic test_ic_read();
    logic [DW-1:0] d;
    d = {32'hDEADBEEF, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h1000;
    #1;
    n_checks++; if (st !== 7'b1000000) begin n_fail++; $display("FAIL icrd_grant: got %b want %b", st, 7'b1000000); end
    @(negedge clk);
    bus.ic_req_valid = 1'b0; bus.ic_req_addr = $urandom; bus.mem_req_ready = 1'b1;
    #1;
    n_checks++; if (st !== 7'b0000110) begin n_fail++; $display("FAIL icrd_issue: got %b want %b", st, 7'b0000110); end
    n_checks++; if ({bus.mem_req_rnw, bus.mem_req_addr} !== {1'b1, 32'h1000}) begin n_fail++; $display("FAIL icrd_fields: got %h want %h", {bus.mem_req_rnw, bus.mem_req_addr}, {1'b1, 32'h1000}); end
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    n_checks++; if (st !== 7'b0000010) begin n_fail++; $display("FAIL icrd_wait1: got %b want %b", st, 7'b0000010); end
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = d;
    #1;
    n_checks++; if (st !== 7'b0000010) begin n_fail++; $display("FAIL icrd_wait2: got %b want %b", st, 7'b0000010); end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = rnd_line();
    #1;
    n_checks++; if (st !== 7'b0010000) begin n_fail++; $display("FAIL icrd_resp: got %b want %b", st, 7'b0010000); end
    n_checks++; if (bus.ic_resp_data !== d) begin n_fail++; $display("FAIL icrd_data: got %h want %h", bus.ic_resp_data, d); end
    @(negedge clk);
    #1;
    n_checks++; if (st !== 7'b0) begin n_fail++; $display("FAIL icrd_after: got %b want %b", st, 7'b0); end
    n_checks++; if (bus.ic_resp_data !== d) begin n_fail++; $display("FAIL icrd_hold: got %h want %h", bus.ic_resp_data, d); end
  endtask

  task automatic test_dc_write();
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    a = $urandom; w = rnd_line();
    @(negedge clk);
    bus.dc_req_valid = 1'b1; bus.dc_req_rnw = 1'b0; bus.dc_req_addr = a; bus.dc_req_wdata = w;
    bus.mem_req_ready = 1'b0;
    #1;
    n_checks++; if (st !== 7'b0100000) begin n_fail++; $display("FAIL dcwr_grant: got %b want %b", st, 7'b0100000); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.dc_req_valid = 1'b0; bus.dc_req_rnw = 1'b1; bus.dc_req_addr = $urandom; bus.dc_req_wdata = rnd_line();
      bus.mem_req_ready = (i == 3);
      #1;
      n_checks++; if (st !== 7'b0000111) begin n_fail++; $display("FAIL dcwr_issue%0d: got %b want %b", i, st, 7'b0000111); end
      n_checks++; if ({bus.mem_req_rnw, bus.mem_req_addr, bus.mem_req_wdata} !== {1'b0, a, w}) begin n_fail++; $display("FAIL dcwr_fields%0d: got %h want %h", i, {bus.mem_req_rnw, bus.mem_req_addr, bus.mem_req_wdata}, {1'b0, a, w}); end
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    n_checks++; if (st !== 7'b0000001) begin n_fail++; $display("FAIL dcwr_done: got %b want %b", st, 7'b0000001); end
    @(negedge clk);
    #1;
    n_checks++; if (st !== 7'b0000001) begin n_fail++; $display("FAIL dcwr_noresp: got %b want %b", st, 7'b0000001); end
  endtask

  task automatic test_contention();
    bit got[6];
    bit exp_d;
    int g;
    int cnt;
    g = 0;
    @(negedge clk);
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = $urandom;
    bus.dc_req_valid = 1'b1; bus.dc_req_rnw = 1'b0; bus.dc_req_addr = $urandom; bus.dc_req_wdata = rnd_line();
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = rnd_line();
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.ic_req_ready && bus.dc_req_ready) begin
        n_checks++; n_fail++; $display("FAIL cont_double_grant: got both readies want one");
      end else if (bus.dc_req_ready || bus.ic_req_ready) begin
        got[g] = bus.dc_req_ready;
        g++;
      end
      if (g >= 6) break;
      @(negedge clk);
    end
    n_checks++; if (g !== 6) begin n_fail++; $display("FAIL cont_timeout: got %0d grants want 6", g); end
    // Both held continuously: starvation budget allows SMAX data grants then one instruction grant
    cnt = 0;
    for (int k = 0; k < g; k++) begin
      if (FAIR && cnt == SMAX) begin exp_d = 1'b0; cnt = 0; end
      else begin exp_d = 1'b1; cnt++; end
      n_checks++; if (got[k] !== exp_d) begin n_fail++; $display("FAIL cont_grant%0d: got %s want %s", k, got[k] ? "D" : "I", exp_d ? "D" : "I"); end
    end
    @(negedge clk);
    bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.mem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_drain: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = $urandom;
    @(negedge clk);
    bus.ic_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    n_checks++; if (st[6:1] !== 6'b000001) begin n_fail++; $display("FAIL rstmid_wait: got %b want %b", st[6:1], 6'b000001); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (st !== 7'b0) begin n_fail++; $display("FAIL rstmid_async: got %b want %b", st, 7'b0); end
    @(negedge clk);
    reset = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = rnd_line();
    #1;
    n_checks++; if (st !== 7'b0) begin n_fail++; $display("FAIL rstmid_late_resp: got %b want %b", st, 7'b0); end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    n_checks++; if (st !== 7'b0) begin n_fail++; $display("FAIL rstmid_nopulse: got %b want %b", st, 7'b0); end
    n_checks++; if (bus.ic_resp_data !== 128'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", bus.ic_resp_data); end
  endtask

  task automatic test_spurious();
    logic [AW-1:0] a;
    logic [DW-1:0] r;
    a = $urandom; r = rnd_line();
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = rnd_line();
    #1;
    n_checks++; if (st[6:1] !== 6'b0) begin n_fail++; $display("FAIL spur_idle: got %b want %b", st[6:1], 6'b0); end
    @(negedge clk);
    bus.dc_req_valid = 1'b1; bus.dc_req_rnw = 1'b1; bus.dc_req_addr = a; bus.mem_resp_data = rnd_line();
    #1;
    n_checks++; if (st[6:1] !== 6'b010000) begin n_fail++; $display("FAIL spur_grant: got %b want %b", st[6:1], 6'b010000); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.dc_req_valid = 1'b0; bus.mem_req_ready = (i == 1); bus.mem_resp_data = rnd_line();
      #1;
      n_checks++; if (st !== 7'b0000111) begin n_fail++; $display("FAIL spur_issue%0d: got %b want %b", i, st, 7'b0000111); end
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    #1;
    n_checks++; if (st !== 7'b0000011) begin n_fail++; $display("FAIL spur_wait: got %b want %b", st, 7'b0000011); end
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = r;
    @(negedge clk);
    bus.mem_resp_data = rnd_line();
    #1;
    n_checks++; if (st !== 7'b0001001) begin n_fail++; $display("FAIL spur_resp: got %b want %b", st, 7'b0001001); end
    n_checks++; if (bus.dc_resp_data !== r) begin n_fail++; $display("FAIL spur_data: got %h want %h", bus.dc_resp_data, r); end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    n_checks++; if (st !== 7'b0000001) begin n_fail++; $display("FAIL spur_second_ignored: got %b want %b", st, 7'b0000001); end
    n_checks++; if (bus.dc_resp_data !== r) begin n_fail++; $display("FAIL spur_hold: got %h want %h", bus.dc_resp_data, r); end
  endtask

  task automatic test_back_to_back();
    bit            ic_p, dc_p, dc_rnw, win_dc, e_rnw, rv_ic, rv_dc;
    logic [AW-1:0] ic_a, dc_a, e_addr;
    logic [DW-1:0] dc_w, e_w, e_data;
    int            cnt, stall, lat;
    ic_p = 1'b0; dc_p = 1'b0; cnt = 0; rv_ic = 1'b0; rv_dc = 1'b0;
    dc_rnw = 1'b0; ic_a = '0; dc_a = '0; dc_w = '0; e_data = '0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!ic_p && $urandom_range(0, 1) == 1) begin ic_p = 1'b1; ic_a = $urandom; end
      if (!dc_p && $urandom_range(0, 1) == 1) begin dc_p = 1'b1; dc_a = $urandom; dc_rnw = 1'($urandom_range(0, 1)); dc_w = rnd_line(); end
      if (!ic_p && !dc_p) begin ic_p = 1'b1; ic_a = $urandom; end
      bus.ic_req_valid = ic_p; bus.ic_req_addr = ic_a;
      bus.dc_req_valid = dc_p; bus.dc_req_rnw = dc_rnw; bus.dc_req_addr = dc_a; bus.dc_req_wdata = dc_w;
      bus.mem_req_ready = 1'($urandom_range(0, 1));
      bus.mem_resp_valid = 1'($urandom_range(0, 1)); bus.mem_resp_data = rnd_line();
      #1;
      n_checks++; if ({busy, bus.ic_resp_valid, bus.dc_resp_valid} !== {1'b0, rv_ic, rv_dc}) begin n_fail++; $display("FAIL rnd%0d_idle: got %b want %b", t, {busy, bus.ic_resp_valid, bus.dc_resp_valid}, {1'b0, rv_ic, rv_dc}); end
      if (rv_ic) begin n_checks++; if (bus.ic_resp_data !== e_data) begin n_fail++; $display("FAIL rnd%0d_icdata: got %h want %h", t, bus.ic_resp_data, e_data); end end
      if (rv_dc) begin n_checks++; if (bus.dc_resp_data !== e_data) begin n_fail++; $display("FAIL rnd%0d_dcdata: got %h want %h", t, bus.dc_resp_data, e_data); end end
      // Reference arbitration: data cache first unless the instruction cache has waited out its budget
      win_dc = dc_p && !(FAIR && ic_p && cnt == SMAX);
      if (win_dc && ic_p) cnt++; else cnt = 0;
      n_checks++; if ({bus.ic_req_ready, bus.dc_req_ready} !== {~win_dc, win_dc}) begin n_fail++; $display("FAIL rnd%0d_grant: got %b want %b", t, {bus.ic_req_ready, bus.dc_req_ready}, {~win_dc, win_dc}); end
      if (win_dc) begin e_rnw = dc_rnw; e_addr = dc_a; e_w = dc_w; dc_p = 1'b0; end
      else begin e_rnw = 1'b1; e_addr = ic_a; e_w = '0; ic_p = 1'b0; end
      rv_ic = 1'b0; rv_dc = 1'b0;
      stall = $urandom_range(0, 2);
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        bus.ic_req_valid = ic_p; bus.dc_req_valid = dc_p;
        bus.mem_req_ready = (s == stall);
        bus.mem_resp_valid = 1'($urandom_range(0, 1)); bus.mem_resp_data = rnd_line();
        #1;
        n_checks++; if (st !== {5'b00001, 1'b1, win_dc}) begin n_fail++; $display("FAIL rnd%0d_issue: got %b want %b", t, st, {5'b00001, 1'b1, win_dc}); end
        n_checks++; if ({bus.mem_req_rnw, bus.mem_req_addr} !== {e_rnw, e_addr}) begin n_fail++; $display("FAIL rnd%0d_fields: got %h want %h", t, {bus.mem_req_rnw, bus.mem_req_addr}, {e_rnw, e_addr}); end
        if (!e_rnw) begin n_checks++; if (bus.mem_req_wdata !== e_w) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", t, bus.mem_req_wdata, e_w); end end
      end
      if (e_rnw) begin
        lat = $urandom_range(0, 2);
        for (int l = 0; l <= lat; l++) begin
          @(negedge clk);
          bus.mem_req_ready = 1'($urandom_range(0, 1));
          bus.mem_resp_valid = (l == lat);
          if (l == lat) begin e_data = rnd_line(); bus.mem_resp_data = e_data; end
          else bus.mem_resp_data = rnd_line();
          #1;
          n_checks++; if (st !== {5'b00000, 1'b1, win_dc}) begin n_fail++; $display("FAIL rnd%0d_wait: got %b want %b", t, st, {5'b00000, 1'b1, win_dc}); end
        end
        rv_ic = ~win_dc; rv_dc = win_dc;
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++; if ({busy, bus.ic_resp_valid, bus.dc_resp_valid} !== {1'b0, rv_ic, rv_dc}) begin n_fail++; $display("FAIL rnd_final: got %b want %b", {busy, bus.ic_resp_valid, bus.dc_resp_valid}, {1'b0, rv_ic, rv_dc}); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_ic_read();
    test_dc_write();
    test_contention();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1);
  end

endmodule
